// File: rtl/bshift_pkg.sv
`default_nettype none
// ============================================================================
// Module   : bshift_pkg
// Brief    : Shared mode encoding and stage-count helper for the pipelined
//            barrel shifter.
// Revision : 1.0 - initial release
// ============================================================================
package bshift_pkg;

    typedef enum logic [1:0] {
        LSR = 2'd0,
        LSL = 2'd1,
        ASR = 2'd2,
        ROR = 2'd3
    } shift_mode_e;

    // One stage per bit of the shift amount.
    function automatic int bshift_shw(input int width);
        return $clog2(width);
    endfunction

endpackage
`default_nettype wire

// File: rtl/bshift_stage.sv
`default_nettype none
// ============================================================================
// Module   : bshift_stage
// Brief    : One registered shifter stage; shifts by DIST when its amount bit
//            is set. Sticky tracking present only with BSHIFT_STICKY_EN.
// Revision : 1.0 - initial release
// ============================================================================
module bshift_stage
    import bshift_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int SHW   = 3,
    parameter int DIST  = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    input  logic [WIDTH-1:0] in_data,
    input  logic [SHW-1:0]   in_amt,
    input  logic [1:0]       in_mode,
    input  logic             adv_in,
    output logic             adv_out,
    output logic             out_valid,
    output logic [WIDTH-1:0] out_data,
    output logic [SHW-1:0]   out_amt,
    output logic [1:0]       out_mode
`ifdef BSHIFT_STICKY_EN
    ,
    input  logic             in_sticky,
    output logic             out_sticky
`endif
);

    localparam int BIT = $clog2(DIST);

    shift_mode_e      w_mode;
    logic [WIDTH-1:0] w_shifted;
    logic             valid_d, valid_q;
    logic [WIDTH-1:0] data_d, data_q;
    logic [SHW-1:0]   amt_d, amt_q;
    logic [1:0]       mode_d, mode_q;
`ifdef BSHIFT_STICKY_EN
    logic             w_discard;
    logic             sticky_d, sticky_q;
`endif

    always_comb begin
        w_mode    = shift_mode_e'(in_mode);
        w_shifted = in_data;
`ifdef BSHIFT_STICKY_EN
        w_discard = 1'b0;
`endif
        if (in_amt[BIT]) begin
            case (w_mode)
                LSR: begin
                    w_shifted = in_data >> DIST;
`ifdef BSHIFT_STICKY_EN
                    w_discard = |in_data[DIST-1:0];
`endif
                end
                LSL: begin
                    w_shifted = in_data << DIST;
`ifdef BSHIFT_STICKY_EN
                    w_discard = |in_data[WIDTH-1:WIDTH-DIST];
`endif
                end
                ASR: begin
                    // The current MSB is still the original sign, so each
                    // stage re-replicates it.
                    w_shifted = $signed(in_data) >>> DIST;
`ifdef BSHIFT_STICKY_EN
                    w_discard = |in_data[DIST-1:0];
`endif
                end
                ROR: begin
                    w_shifted = {in_data[DIST-1:0], in_data[WIDTH-1:DIST]};
                end
                default: begin
                    w_shifted = in_data;
                end
            endcase
        end
    end

    always_comb begin
        adv_out = !valid_q || adv_in;
        valid_d = valid_q;
        data_d  = data_q;
        amt_d   = amt_q;
        mode_d  = mode_q;
`ifdef BSHIFT_STICKY_EN
        sticky_d = sticky_q;
`endif
        // An empty stage always loads, which lets bubbles collapse.
        if (adv_out) begin
            valid_d = in_valid;
            data_d  = w_shifted;
            amt_d   = in_amt;
            mode_d  = in_mode;
`ifdef BSHIFT_STICKY_EN
            sticky_d = in_sticky | w_discard;
`endif
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            valid_q <= 1'b0;
            data_q  <= '0;
            amt_q   <= '0;
            mode_q  <= '0;
`ifdef BSHIFT_STICKY_EN
            sticky_q <= 1'b0;
`endif
        end else begin
            valid_q <= valid_d;
            data_q  <= data_d;
            amt_q   <= amt_d;
            mode_q  <= mode_d;
`ifdef BSHIFT_STICKY_EN
            sticky_q <= sticky_d;
`endif
        end
    end

    assign out_valid = valid_q;
    assign out_data  = data_q;
    assign out_amt   = amt_q;
    assign out_mode  = mode_q;
`ifdef BSHIFT_STICKY_EN
    assign out_sticky = sticky_q;
`endif

endmodule
`default_nettype wire

// File: rtl/pipelined_barrel_shifter.sv
`default_nettype none
// ============================================================================
// Module   : pipelined_barrel_shifter
// Brief    : log2(WIDTH)-stage pipelined barrel shifter (LSR/LSL/ASR/ROR)
//            with valid/ready on both sides. Define BSHIFT_STICKY_EN to add
//            the out_sticky port.
// Revision : 1.0 - initial release
// ============================================================================
module pipelined_barrel_shifter
    import bshift_pkg::*;
#(
    parameter  int WIDTH = 8,
    localparam int SHW   = bshift_shw(WIDTH)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    input  logic [SHW-1:0]   in_amt,
    input  logic [1:0]       in_mode,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data
`ifdef BSHIFT_STICKY_EN
    ,
    output logic             out_sticky
`endif
);

    // Index k is the input of stage k; index SHW is the last stage's output.
    logic [SHW:0]     valid_pipe;
    logic [SHW:0]     adv_pipe;
    logic [WIDTH-1:0] data_pipe [SHW+1];
    logic [SHW-1:0]   amt_pipe  [SHW+1];
    logic [1:0]       mode_pipe [SHW+1];
`ifdef BSHIFT_STICKY_EN
    logic [SHW:0]     sticky_pipe;
`endif
    logic             unused_tail;

    assign valid_pipe[0] = in_valid;
    assign data_pipe[0]  = in_data;
    assign amt_pipe[0]   = in_amt;
    assign mode_pipe[0]  = in_mode;
    assign adv_pipe[SHW] = out_ready;
`ifdef BSHIFT_STICKY_EN
    assign sticky_pipe[0] = 1'b0;
`endif

    generate
        for (genvar k = 0; k < SHW; k++) begin : g_stage
            bshift_stage #(
                .WIDTH (WIDTH),
                .SHW   (SHW),
                .DIST  (1 << k)
            ) u_stage (
                .clk       (clk),
                .rst       (rst),
                .in_valid  (valid_pipe[k]),
                .in_data   (data_pipe[k]),
                .in_amt    (amt_pipe[k]),
                .in_mode   (mode_pipe[k]),
                .adv_in    (adv_pipe[k+1]),
                .adv_out   (adv_pipe[k]),
                .out_valid (valid_pipe[k+1]),
                .out_data  (data_pipe[k+1]),
                .out_amt   (amt_pipe[k+1]),
                .out_mode  (mode_pipe[k+1])
`ifdef BSHIFT_STICKY_EN
                ,
                .in_sticky (sticky_pipe[k]),
                .out_sticky(sticky_pipe[k+1])
`endif
            );
        end
    endgenerate

    assign in_ready  = adv_pipe[0];
    assign out_valid = valid_pipe[SHW];
    assign out_data  = data_pipe[SHW];
`ifdef BSHIFT_STICKY_EN
    assign out_sticky = sticky_pipe[SHW];
`endif

    // Amount and mode are spent once the last stage has used them.
    assign unused_tail = ^{amt_pipe[SHW], mode_pipe[SHW]};

endmodule
`default_nettype wire

// File: tb/tb_pipelined_barrel_shifter.sv
`default_nettype none
// ============================================================================
// Module   : tb_pipelined_barrel_shifter
// Brief    : Randomized self-checking bench with a scoreboard reference model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_pipelined_barrel_shifter;

    localparam int W   = 8;
    localparam int SHW = 3;

    typedef struct {
        logic [W-1:0] data;
        logic         sticky;
        int           t;
    } exp_t;

    logic           clk = 1'b0;
    logic           rst = 1'b1;
    logic           in_valid = 1'b0;
    logic           in_ready;
    logic [W-1:0]   in_data = '0;
    logic [SHW-1:0] in_amt = '0;
    logic [1:0]     in_mode = '0;
    logic           out_valid;
    logic           out_ready = 1'b1;
    logic [W-1:0]   out_data;
`ifdef BSHIFT_STICKY_EN
    logic           out_sticky;
`endif

    exp_t sb[$];
    int   checks  = 0;
    int   errors  = 0;
    int   cyc     = 0;
    int   acc_cnt = 0;
    bit   lat_en  = 1'b0;

    pipelined_barrel_shifter #(.WIDTH(W)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .in_amt    (in_amt),
        .in_mode   (in_mode),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data)
`ifdef BSHIFT_STICKY_EN
        ,
        .out_sticky(out_sticky)
`endif
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask

    // Shift semantics from plain integer arithmetic on the whole amount.
    function automatic exp_t model(input logic [W-1:0] d, input int a, input logic [1:0] m);
        exp_t        e;
        int unsigned x;
        int          sx;
        x = d;
        e.t = 0;
        e.sticky = 1'b0;
        case (m)
            2'd0: begin
                e.data   = W'(x >> a);
                e.sticky = (x & ((1 << a) - 1)) != 0;
            end
            2'd1: begin
                e.data   = W'(x << a);
                e.sticky = (x >> (W - a)) != 0;
            end
            2'd2: begin
                sx       = d[W-1] ? int'(x) - (1 << W) : int'(x);
                e.data   = W'(sx >>> a);
                e.sticky = (x & ((1 << a) - 1)) != 0;
            end
            default: begin
                e.data = W'((x >> a) | (x << (W - a)));
            end
        endcase
        return e;
    endfunction

    always @(negedge clk) begin
        if (rst) begin
            sb.delete();
        end else begin
            if (out_valid) begin
                if (sb.size() == 0) begin
                    check("stale_out", 32'(out_valid), 32'd0);
                end else begin
                    check("out_data", 32'(out_data), 32'(sb[0].data));
`ifdef BSHIFT_STICKY_EN
                    check("out_sticky", 32'(out_sticky), 32'(sb[0].sticky));
`endif
                    if (out_ready) begin
                        if (lat_en) check("latency", 32'(cyc - sb[0].t), 32'(SHW));
                        void'(sb.pop_front());
                    end
                end
            end
            if (in_valid && in_ready) begin
                exp_t e;
                e = model(in_data, int'(in_amt), in_mode);
                e.t = cyc;
                sb.push_back(e);
                acc_cnt++;
            end
        end
    end

    task automatic send(input logic [W-1:0] d, input logic [SHW-1:0] a, input logic [1:0] m);
        int n;
        n = 0;
        in_valid = 1'b1;
        in_data  = d;
        in_amt   = a;
        in_mode  = m;
        @(negedge clk);
        while (!in_ready && n < 200) begin
            n++;
            @(negedge clk);
        end
        if (n >= 200) check("send_timeout", 32'(n), 32'd0);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
    endtask

    task automatic send_rand();
        send(8'($urandom_range(0, 255)), 3'($urandom_range(0, 7)), 2'($urandom_range(0, 3)));
    endtask

    task automatic drain();
        int n;
        n = 0;
        while ((sb.size() != 0 || out_valid) && n < 100) begin
            @(posedge clk);
            #1;
            n++;
        end
        check("drain_empty", 32'(sb.size()), 32'd0);
    endtask

    initial begin
        int c0;
        int a0;

        // Beat presented during reset must be ignored.
        rst      = 1'b1;
        in_valid = 1'b1;
        in_data  = 8'hFF;
        in_amt   = 3'd1;
        repeat (3) @(posedge clk);
        #1;
        rst      = 1'b0;
        in_valid = 1'b0;
        @(negedge clk);
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_out_data", 32'(out_data), 32'd0);
        check("rst_in_ready", 32'(in_ready), 32'd1);
`ifdef BSHIFT_STICKY_EN
        check("rst_out_sticky", 32'(out_sticky), 32'd0);
`endif
        @(posedge clk);
        #1;

        lat_en = 1'b1;
        send(8'hB4, 3'd3, 2'd0);
        send(8'h96, 3'd2, 2'd2);
        send(8'h7F, 3'd7, 2'd2);
        send(8'h80, 3'd7, 2'd2);
        send(8'h81, 3'd1, 2'd1);
        send(8'h81, 3'd4, 2'd3);
        for (int m = 0; m < 4; m++) send(8'hA5, 3'd0, 2'(m));
        drain();

        // Back-to-back: one accept per cycle, constant latency.
        c0 = cyc;
        for (int i = 0; i < 8; i++) send_rand();
        check("b2b_accept_cycles", 32'(cyc - c0), 32'd8);
        drain();
        lat_en = 1'b0;

        // Backpressure: three stages fill, then input stalls.
        out_ready = 1'b0;
        a0 = acc_cnt;
        fork
            begin
                for (int i = 0; i < 5; i++) send_rand();
            end
        join_none
        repeat (6) @(posedge clk);
        #1;
        check("bp_accepted", 32'(acc_cnt - a0), 32'd3);
        check("bp_in_ready", 32'(in_ready), 32'd0);
        out_ready = 1'b1;
        wait fork;
        drain();
        check("bp_total", 32'(acc_cnt - a0), 32'd5);

        // Reset with beats in flight.
        for (int i = 0; i < 3; i++) send_rand();
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        check("midrst_out_valid", 32'(out_valid), 32'd0);
        check("midrst_out_data", 32'(out_data), 32'd0);
        repeat (8) @(posedge clk);
        #1;
        check("midrst_quiet", 32'(out_valid), 32'd0);

        // Random traffic with random backpressure.
        fork
            begin
                repeat (400) begin
                    @(posedge clk);
                    #1;
                    out_ready = ($urandom_range(0, 3) != 0);
                end
                out_ready = 1'b1;
            end
        join_none
        for (int i = 0; i < 150; i++) begin
            if ($urandom_range(0, 3) == 0) begin
                @(posedge clk);
                #1;
            end
            send_rand();
        end
        wait fork;
        out_ready = 1'b1;
        drain();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, checks %0d errors %0d", checks, errors);
        $fatal(1, "watchdog expired");
    end

endmodule
`default_nettype wire
